// File: rtl/mtsp_src_operate_nd.sv
// Multi-lane pipelined source-operand modifier (pass/neg/abs/neg-abs, int and float).
// Optional MTSP_SRCOP_SATURATE_EN: integer overflow saturates to MAX instead of wrapping.

module mtsp_src_operate_nd_lane #(
    parameter int DWIDTH      = 32,
    parameter int FP_SIGN_BIT = 23
) (
    input  logic [2:0]        op,
    input  logic [DWIDTH-1:0] x,
    output logic [DWIDTH-1:0] res,
    output logic              ovf
);
    localparam logic [DWIDTH-1:0] MIN = {1'b1, {(DWIDTH-1){1'b0}}};
`ifdef MTSP_SRCOP_SATURATE_EN
    localparam logic [DWIDTH-1:0] MAX = {1'b0, {(DWIDTH-1){1'b1}}};
`endif

    logic is_int, neg, abs_en;
    logic [DWIDTH-1:0] mag, ires;

    assign is_int = op[0];
    assign neg    = op[1];
    assign abs_en = op[2];

    always_comb begin
        mag  = (abs_en && x[DWIDTH-1]) ? -x : x;
        ires = neg ? -mag : mag;
        // only MIN with a single sign change has no representable result
        ovf  = is_int && (x == MIN) && (abs_en ^ neg);
        res  = x;
        if (is_int) begin
`ifdef MTSP_SRCOP_SATURATE_EN
            res = ovf ? MAX : ires;
`else
            res = ires;
`endif
        end else begin
            res[FP_SIGN_BIT] = (abs_en ? 1'b0 : x[FP_SIGN_BIT]) ^ neg;
        end
    end
endmodule

module mtsp_src_operate_nd #(
    parameter int LANES       = 4,
    parameter int DWIDTH      = 32,
    parameter int FP_SIGN_BIT = 23,
    parameter int PIPE_DEPTH  = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [LANES*3-1:0]        IN_OP,
    input  logic [LANES*DWIDTH-1:0]   IN_DATA,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [LANES*DWIDTH-1:0]   OUT_DATA,
    output logic [LANES-1:0]          OUT_OVF,
    input  logic                      OVF_CLR,
    output logic                      OVF_STICKY
);
    logic [LANES-1:0][DWIDTH-1:0] op_res;
    logic [LANES-1:0]             op_ovf;

    logic [PIPE_DEPTH-1:0]                         vld_pipe;
    logic [PIPE_DEPTH-1:0]                         ld;
    logic [PIPE_DEPTH-1:0][LANES*DWIDTH-1:0]       data_pipe;
    logic [PIPE_DEPTH-1:0][LANES-1:0]              ovf_pipe;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mtsp_src_operate_nd_lane #(
            .DWIDTH      (DWIDTH),
            .FP_SIGN_BIT (FP_SIGN_BIT)
        ) u_lane (
            .op  (IN_OP[3*i +: 3]),
            .x   (IN_DATA[DWIDTH*i +: DWIDTH]),
            .res (op_res[i]),
            .ovf (op_ovf[i])
        );
    end

    // stage k can load iff some stage at or downstream of k has a hole, or the sink drains
    always_comb begin
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            ld[k] = OUT_READY;
            for (int j = k; j < PIPE_DEPTH; j++)
                if (!vld_pipe[j]) ld[k] = 1'b1;
        end
    end

    assign IN_READY   = ld[0] & ~RST;
    assign OUT_VALID  = vld_pipe[PIPE_DEPTH-1];
    assign OUT_DATA   = data_pipe[PIPE_DEPTH-1];
    assign OUT_OVF    = ovf_pipe[PIPE_DEPTH-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
            ovf_pipe  <= '0;
        end else begin
            if (ld[0]) begin
                vld_pipe[0] <= IN_VALID;
                if (IN_VALID) begin
                    data_pipe[0] <= op_res;
                    ovf_pipe[0]  <= op_ovf;
                end
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (ld[k]) begin
                    vld_pipe[k] <= vld_pipe[k-1];
                    if (vld_pipe[k-1]) begin
                        data_pipe[k] <= data_pipe[k-1];
                        ovf_pipe[k]  <= ovf_pipe[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            OVF_STICKY <= 1'b0;
        else if (OUT_VALID && OUT_READY && |OUT_OVF)
            OVF_STICKY <= 1'b1;
        else if (OVF_CLR)
            OVF_STICKY <= 1'b0;
    end
endmodule

// File: tb/tb_mtsp_src_operate_nd.sv
// Bench for mtsp_src_operate_nd: directed vector table, stall/reset sequences,
// randomized traffic against a scoreboard model, and a 1-lane/1-stage instance.

module tb_mtsp_src_operate_nd;
    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int PD    = 2;
`ifdef MTSP_SRCOP_SATURATE_EN
    localparam logic [31:0] OVF_RES   = 32'h7FFFFFFF;
    localparam logic [15:0] OVF_RES16 = 16'h7FFF;
`else
    localparam logic [31:0] OVF_RES   = 32'h80000000;
    localparam logic [15:0] OVF_RES16 = 16'h8000;
`endif
    localparam longint IMAX = 64'sd2147483647;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic                    IN_VALID, IN_READY, OUT_VALID, OUT_READY, OVF_CLR, OVF_STICKY;
    logic [LANES*3-1:0]      IN_OP;
    logic [LANES*DW-1:0]     IN_DATA, OUT_DATA;
    logic [LANES-1:0]        OUT_OVF;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf_clr, b_ovf_sticky;
    logic [2:0]  b_in_op;
    logic [15:0] b_in_data, b_out_data;
    logic [0:0]  b_out_ovf;

    mtsp_src_operate_nd #(.LANES(LANES), .DWIDTH(DW), .FP_SIGN_BIT(23), .PIPE_DEPTH(PD)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OP(IN_OP),
        .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_OVF(OUT_OVF), .OVF_CLR(OVF_CLR), .OVF_STICKY(OVF_STICKY));

    mtsp_src_operate_nd #(.LANES(1), .DWIDTH(16), .FP_SIGN_BIT(15), .PIPE_DEPTH(1)) dut_b (
        .CLK(CLK), .RST(RST), .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_OP(b_in_op),
        .IN_DATA(b_in_data), .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .OUT_DATA(b_out_data),
        .OUT_OVF(b_out_ovf), .OVF_CLR(b_ovf_clr), .OVF_STICKY(b_ovf_sticky));

    typedef struct {
        logic [11:0]  op;
        logic [127:0] data;
        logic [127:0] exp_d;
        logic [3:0]   exp_o;
        bit           sticky;
    } vec_t;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   o;
    } beat_t;

    beat_t  sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     n_out = 0;
    bit     exp_sticky = 0;
    bit     hold_valid = 0;
    logic [127:0] hold_d;
    logic [3:0]   hold_o;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer modes via signed arithmetic on a wide value, float via sign rule.
    function automatic void ref_lane(input logic [2:0] op, input logic [31:0] x,
                                     output logic [31:0] r, output logic o);
        longint v;
        if (!op[0]) begin
            r = x;
            r[23] = (op[2] ? 1'b0 : x[23]) ^ op[1];
            o = 1'b0;
        end else begin
            v = longint'($signed(x));
            if (op[2] && v < 0) v = -v;
            if (op[1]) v = -v;
            o = (v > IMAX);
            r = o ? OVF_RES : v[31:0];
        end
    endfunction

    function automatic beat_t model(input logic [11:0] op, input logic [127:0] d);
        beat_t m;
        logic [31:0] r;
        logic o;
        for (int l = 0; l < LANES; l++) begin
            ref_lane(op[3*l +: 3], d[32*l +: 32], r, o);
            m.d[32*l +: 32] = r;
            m.o[l] = o;
        end
        return m;
    endfunction

    function automatic logic [31:0] rdat();
        case ($urandom_range(0, 4))
            0: return 32'h80000000;
            1: return 32'h7FFFFFFF;
            2: return 32'h00000000;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_beat();
        for (int l = 0; l < LANES; l++) begin
            IN_OP[3*l +: 3]    = 3'($urandom_range(0, 7));
            IN_DATA[32*l +: 32] = rdat();
        end
    endtask

    // Scoreboard / sticky / stall-stability monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        beat_t e;
        if (RST) begin
            sb.delete();
            exp_sticky = 0;
            hold_valid = 0;
        end else begin
            chk("sticky_track", OVF_STICKY, exp_sticky);
            if (!IN_READY) chk("ready_low_when_full", sb.size(), PD);
            if (hold_valid && OUT_VALID) begin
                chk("stall_data_stable", OUT_DATA, hold_d);
                chk("stall_ovf_stable", OUT_OVF, hold_o);
            end
            hold_valid = OUT_VALID && !OUT_READY;
            hold_d = OUT_DATA;
            hold_o = OUT_OVF;
            if (OUT_VALID && OUT_READY) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", OUT_DATA, e.d);
                    chk("sb_ovf", OUT_OVF, e.o);
                    if (|e.o) exp_sticky = 1;
                    else if (OVF_CLR) exp_sticky = 0;
                end
            end else if (OVF_CLR) begin
                exp_sticky = 0;
            end
            if (IN_VALID && IN_READY) sb.push_back(model(IN_OP, IN_DATA));
        end
    end

    // Entered and left at posedge+1 with an empty pipe and OUT_READY=1.
    task automatic send_vec(input vec_t v);
        int lat;
        IN_OP = v.op; IN_DATA = v.data; IN_VALID = 1;
        #1 chk("vec_in_ready", IN_READY, 1);
        @(posedge CLK); #1;
        IN_VALID = 0;
        lat = 1;
        while (!OUT_VALID && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("vec_latency", lat, PD);
        chk("vec_data", OUT_DATA, v.exp_d);
        chk("vec_ovf", OUT_OVF, v.exp_o);
        @(posedge CLK); #1;
        chk("vec_sticky", OVF_STICKY, v.sticky);
    endtask

    vec_t tbl[4];

    initial begin
        int sent, c, out0;
        bit need_new, saw_stall;

        tbl[0] = '{op:   {3'b001, 3'b000, 3'b110, 3'b010},
                   data: {32'h80000000, 32'hDEADBEEF, 32'h00400000, 32'h12BF8000},
                   exp_d:{32'h80000000, 32'hDEADBEEF, 32'h00C00000, 32'h123F8000},
                   exp_o: 4'b0000, sticky: 0};
        tbl[1] = '{op:   {3'b100, 3'b111, 3'b101, 3'b011},
                   data: {32'hFF800001, 32'h80000000, 32'hFFFFFFF6, 32'h00000005},
                   exp_d:{32'hFF000001, 32'h80000000, 32'h0000000A, 32'hFFFFFFFB},
                   exp_o: 4'b0000, sticky: 0};
        tbl[2] = '{op:   {3'b000, 3'b011, 3'b000, 3'b000},
                   data: {32'h0, 32'h80000000, 32'h0, 32'h0},
                   exp_d:{32'h0, OVF_RES, 32'h0, 32'h0},
                   exp_o: 4'b0100, sticky: 1};
        tbl[3] = '{op:   {3'b011, 3'b001, 3'b101, 3'b111},
                   data: {32'h0, 32'h7FFFFFFF, 32'h80000000, 32'h00000007},
                   exp_d:{32'h0, 32'h7FFFFFFF, OVF_RES, 32'hFFFFFFF9},
                   exp_o: 4'b0010, sticky: 1};

        IN_VALID = 0; IN_OP = '0; IN_DATA = '0; OUT_READY = 1; OVF_CLR = 0;
        b_in_valid = 0; b_in_op = '0; b_in_data = '0; b_out_ready = 1; b_ovf_clr = 0;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_out_data", OUT_DATA, 0);
        chk("rst_out_ovf", OUT_OVF, 0);
        chk("rst_sticky", OVF_STICKY, 0);
        RST = 0;
        @(posedge CLK); #1;

        for (int i = 0; i < 4; i++) send_vec(tbl[i]);

        OVF_CLR = 1;
        @(posedge CLK); #1;
        OVF_CLR = 0;
        chk("sticky_cleared", OVF_STICKY, 0);

        // clear held high across a new overflow: the set must win
        OVF_CLR = 1;
        send_vec(tbl[2]);
        OVF_CLR = 0;

        // 10-beat stream with the sink stalled for cycles 3..7
        sent = 0; c = 0; out0 = n_out; need_new = 1; saw_stall = 0;
        while ((sent < 10 || sb.size() > 0) && c < 200) begin
            OUT_READY = !(c >= 3 && c <= 7);
            if (sent < 10) begin
                if (need_new) rand_beat();
                IN_VALID = 1;
            end else begin
                IN_VALID = 0;
            end
            #1;
            if (!IN_READY) saw_stall = 1;
            need_new = IN_VALID && IN_READY;
            if (need_new) sent++;
            @(posedge CLK); #1;
            c++;
        end
        IN_VALID = 0; OUT_READY = 1;
        chk("stream_count", n_out - out0, 10);
        chk("stream_saw_backpressure", saw_stall, 1);

        // reset with two overflow beats in flight
        OUT_READY = 0;
        IN_OP = tbl[2].op; IN_DATA = tbl[2].data; IN_VALID = 1;
        repeat (2) @(posedge CLK);
        #1;
        IN_VALID = 0;
        RST = 1;
        #1 chk("midrst_in_ready", IN_READY, 0);
        @(posedge CLK); #1;
        RST = 0;
        OUT_READY = 1;
        chk("midrst_out_valid", OUT_VALID, 0);
        chk("midrst_sticky", OVF_STICKY, 0);
        chk("midrst_out_data", OUT_DATA, 0);
        send_vec(tbl[1]);

        // random traffic, inputs held until accepted
        need_new = 1;
        for (int i = 0; i < 400; i++) begin
            OUT_READY = ($urandom_range(0, 9) < 7);
            OVF_CLR   = ($urandom_range(0, 9) == 0);
            if (need_new) begin
                IN_VALID = ($urandom_range(0, 9) < 7);
                rand_beat();
            end
            #1;
            need_new = !IN_VALID || IN_READY;
            @(posedge CLK); #1;
        end
        IN_VALID = 0; OVF_CLR = 0; OUT_READY = 1;
        c = 0;
        while (sb.size() > 0 && c < 20) begin
            @(posedge CLK); #1;
            c++;
        end
        chk("random_drained", sb.size(), 0);

        // 1-lane, 16-bit, single-stage instance: 1-cycle latency, back-to-back
        begin
            logic [2:0]  bop [3] = '{3'b101, 3'b011, 3'b010};
            logic [15:0] bdin[3] = '{16'h8000, 16'h0003, 16'h1234};
            logic [15:0] bexp[3] = '{OVF_RES16, 16'hFFFD, 16'h9234};
            logic        bovf[3] = '{1'b1, 1'b0, 1'b0};
            for (int j = 0; j < 3; j++) begin
                b_in_op = bop[j]; b_in_data = bdin[j]; b_in_valid = 1;
                #1 chk("b_in_ready", b_in_ready, 1);
                @(posedge CLK); #1;
                chk("b_out_valid", b_out_valid, 1);
                chk("b_out_data", b_out_data, bexp[j]);
                chk("b_out_ovf", b_out_ovf, bovf[j]);
            end
            b_in_valid = 0;
            @(posedge CLK); #1;
            chk("b_drained", b_out_valid, 0);
            chk("b_sticky", b_ovf_sticky, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
